// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 entries, r0 hardwired to zero, two combinational read ports.
// Define WB_BYPASS_EN to forward the same-cycle write-back value onto matching read ports.
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      data_load,
  input  logic [4:0]       dst,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [31:0]      rs_data,
  output logic [31:0]      rt_data,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] wb_count
);

  logic [31:0]      r_mem [32];
  logic [CNT_W-1:0] r_wb_count;
  logic             w_commit;
  logic [31:0]      w_rs_data;
  logic [31:0]      w_rt_data;

  assign wb_data  = mem_to_reg ? data_load : alu_result;
  assign w_commit = reg_write && (dst != 5'd0);

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_mem[dst] <= wb_data;
      r_wb_count <= r_wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_rs_data = (rs_addr == 5'd0) ? 32'd0 : r_mem[rs_addr];
    w_rt_data = (rt_addr == 5'd0) ? 32'd0 : r_mem[rt_addr];
`ifdef WB_BYPASS_EN
    // Forwarding is suppressed in reset so the ports read zero there.
    if (rst && w_commit && (dst == rs_addr)) begin
      w_rs_data = wb_data;
    end
    if (rst && w_commit && (dst == rt_addr)) begin
      w_rt_data = wb_data;
    end
`endif
  end

  assign rs_data  = w_rs_data;
  assign rt_data  = w_rt_data;
  assign wb_count = r_wb_count;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, default 16, width of the committed-write counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 reg_write  input  1  write-back enable from the MEM/WB latch.
REQ-005 mem_to_reg  input  1  write-back source select: 1 selects data_load, 0 selects alu_result.
REQ-006 alu_result  input  32  ALU result from the MEM/WB latch.
REQ-007 data_load  input  32  load data from the MEM/WB latch.
REQ-008 dst  input  5  destination register index.
REQ-009 rs_addr  input  5  read port A index.
REQ-010 rt_addr  input  5  read port B index.
REQ-011 rs_data  output  32  read port A data, combinational.
REQ-012 rt_data  output  32  read port B data, combinational.
REQ-013 wb_data  output  32  selected write-back value, combinational.
REQ-014 wb_count  output  CNT_W  count of committed register writes.

Function
REQ-015 Storage: 32 entries x 32 bits; register 0 is hardwired to zero.
REQ-016 Write-back value: wb_data = mem_to_reg ? data_load : alu_result at all times, independent of reg_write.
REQ-017 Commit: at the rising edge of clk, if reg_write=1 and dst!=0, entry[dst] <= wb_data; this is the only write path.
REQ-018 Writes with dst=0 are discarded: entry 0 stays 0 and wb_count does not change.
REQ-019 Write latency: one cycle; the written value is visible on an unbypassed read from the first cycle after the edge.
REQ-020 Reads: rs_data = entry[rs_addr] and rt_data = entry[rt_addr]; index 0 always reads 0.
REQ-021 Both read ports operate independently and may address the same entry in the same cycle.
REQ-022 Commit counter: wb_count increments by 1 on each committed write (REQ-017); it wraps from all-ones to 0.
REQ-023 Simultaneous commit and read of the same index: handled per REQ-029 and REQ-030.

Reset
REQ-024 While rst=0, all 32 entries and wb_count are forced to 0 immediately, without waiting for a clock edge.
REQ-025 While rst=0, rs_data and rt_data read 0; wb_data continues to follow REQ-016.
REQ-026 While rst=0, no write commits, even if a clock edge occurs with reg_write=1.
REQ-027 If reset asserts in the middle of a cycle with a pending write, the write is lost.
REQ-028 The first write can commit at the first rising edge of clk after rst returns to 1.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: if reg_write=1, dst!=0 and dst equals a read index, that read port outputs wb_data in the same cycle (write-through). Port A and port B are bypassed independently.
REQ-030 Macro WB_BYPASS_EN undefined: read ports return the stored value only; a same-cycle write becomes visible in the following cycle.

Verification
REQ-031 Reset check: assert rst=0 asynchronously mid-cycle after writes, then read all 32 indices -> every rs_data and rt_data reads 0x00000000, and wb_count=0.
REQ-032 Write-back select: reg_write=1, dst=5, mem_to_reg=0, alu_result=0x1234_5678, data_load=0xDEAD_BEEF; next cycle read rs_addr=5 -> 0x12345678. Repeat with mem_to_reg=1 and dst=6; read rt_addr=6 -> 0xDEADBEEF.
REQ-033 Register zero: reg_write=1, dst=0, alu_result=0xFFFF_FFFF -> rs_addr=0 reads 0 and wb_count does not change.
REQ-034 Same-cycle bypass: entry 7 holds 0x11; in the same cycle, write dst=7 with alu_result=0x22 and read rs_addr=rt_addr=7 -> both ports read 0x22 with WB_BYPASS_EN defined, and 0x11 without it; the next cycle reads 0x22 in both builds.
REQ-035 Counter wrap: with CNT_W=4, perform 17 commits to dst=1 -> wb_count reads 1; 5 further writes to dst=0 -> wb_count stays 1.
REQ-036 Dual read: entries 3=0xA and 4=0xB; read rs_addr=3 and rt_addr=4 simultaneously -> 0xA and 0xB. Swap the indices -> 0xB and 0xA.
